// File: rtl/r_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : r_chk_pkg
//  Description : Shared definitions for the R-type result checker: supported
//                funct codes, checker state encoding, instruction field
//                positions and the stage-1 pipeline record.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package r_chk_pkg;

   // Supported R-type funct codes
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   // Checker state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_FAIL = 2'd3
   } chk_state_t;

   // Instruction field positions
   localparam int OP_HI = 31;
   localparam int OP_LO = 26;
   localparam int RS_HI = 25;
   localparam int RS_LO = 21;
   localparam int RT_HI = 20;
   localparam int RT_LO = 16;
   localparam int RD_HI = 15;
   localparam int RD_LO = 11;
   localparam int SH_HI = 10;
   localparam int SH_LO = 6;
   localparam int FN_HI = 5;
   localparam int FN_LO = 0;

   // Result of one sampled instruction, handed from stage 1 to stage 2
   typedef struct packed {
      logic        valid;   // an instruction was accepted at the previous edge
      logic        legal;   // R-type with a supported funct
      logic        mism;    // legal and any of F/OF/ZF differed
      logic [31:0] inst;
      logic [31:0] exp_f;
      logic [31:0] got_f;
   } stage1_t;

endpackage
`default_nettype wire

// File: rtl/r_alu_model.sv
`default_nettype none
// ============================================================================
//  Module      : r_alu_model
//  Description : Combinational golden ALU for the supported R-type functs.
//  Ports       : a, b   [31:0] in  - rs / rt operand values
//                shamt  [4:0]  in  - shift amount field
//                funct  [5:0]  in  - funct field
//                f      [31:0] out - expected result
//                of            out - expected overflow (add/sub only)
//                zf            out - expected zero flag
//                legal         out - funct is supported
//  Revision    : 1.0  initial release
// ============================================================================
module r_alu_model
   import r_chk_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   output logic [31:0] f,
   output logic        of,
   output logic        zf,
   output logic        legal
);

   logic [31:0] sum;
   logic [31:0] diff;

   assign sum  = a + b;
   assign diff = a - b;

   always_comb begin
      f     = 32'd0;
      of    = 1'b0;
      legal = 1'b1;
      case (funct)
         F_ADD: begin
            f  = sum;
            // same-sign operands producing a result of the other sign
            of = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         F_SUB: begin
            f  = diff;
            // different-sign operands where the result leaves rs's sign
            of = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         F_AND:   f = a & b;
         F_OR:    f = a | b;
         F_XOR:   f = a ^ b;
         F_NOR:   f = ~(a | b);
         F_SLT:   f = {31'd0, ($signed(a) < $signed(b))};
         F_SLTU:  f = {31'd0, (a < b)};
         F_SLL:   f = b << shamt;
         F_SRL:   f = b >> shamt;
         default: legal = 1'b0;
      endcase
   end

   assign zf = (f == 32'd0);

endmodule
`default_nettype wire

// File: rtl/r_result_checker.sv
`default_nettype none
// ============================================================================
//  Module      : r_result_checker
//  Description : Observes retired R-type instructions, keeps a shadow
//                register file, recomputes the golden ALU result/flags and
//                reports pass/fail with first-mismatch details.
//  Ports       : clk, reset          in  - clock, synchronous active-high reset
//                mon_valid          in  - observation bus holds an instruction
//                Inst_code [31:0]   in  - instruction word
//                ALU_F     [31:0]   in  - CPU result
//                OF, ZF             in  - CPU flags
//                pre_we/addr/data   in  - shadow preload (IDLE only)
//                busy, done         out - state is RUN / DONE
//                fail, pass         out - mismatch seen / done without mismatch
//                chk_cnt  [15:0]    out - compared instructions
//                err_cnt  [15:0]    out - mismatches (saturating)
//                ill_cnt  [15:0]    out - illegal words (saturating)
//                err_inst/exp/got   out - details of the first mismatch
//  Revision    : 1.0  initial release
// ============================================================================
module r_result_checker
   import r_chk_pkg::*;
#(
   parameter int unsigned N_CHECK     = 64,
   parameter bit          STOP_ON_ERR = 1'b1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        mon_valid,
   input  logic [31:0] Inst_code,
   input  logic [31:0] ALU_F,
   input  logic        OF,
   input  logic        ZF,
   input  logic        pre_we,
   input  logic [4:0]  pre_addr,
   input  logic [31:0] pre_data,
   output logic        busy,
   output logic        done,
   output logic        fail,
   output logic        pass,
   output logic [15:0] chk_cnt,
   output logic [15:0] err_cnt,
   output logic [15:0] ill_cnt,
   output logic [31:0] err_inst,
   output logic [31:0] err_exp,
   output logic [31:0] err_got
);

   localparam logic [15:0] LAST_CHK = 16'(N_CHECK - 1);

   chk_state_t  state_q;
   chk_state_t  state_d;
   stage1_t     s1;

   logic [31:0] shadow [32];

   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] exp_f;
   logic        exp_of;
   logic        exp_zf;
   logic        funct_ok;
   logic        legal;
   logic        mism;
   logic        pre_ok;
   logic        accept;
   logic        s1_last;

   assign op    = Inst_code[OP_HI:OP_LO];
   assign rs    = Inst_code[RS_HI:RS_LO];
   assign rt    = Inst_code[RT_HI:RT_LO];
   assign rd    = Inst_code[RD_HI:RD_LO];
   assign shamt = Inst_code[SH_HI:SH_LO];
   assign funct = Inst_code[FN_HI:FN_LO];

   assign pre_ok = pre_we && (state_q == ST_IDLE) && (pre_addr != 5'd0);

   // A preload landing in the same cycle as the instruction is visible to it
   assign rs_val = (pre_ok && (pre_addr == rs)) ? pre_data : shadow[rs];
   assign rt_val = (pre_ok && (pre_addr == rt)) ? pre_data : shadow[rt];

   r_alu_model u_alu (
      .a     (rs_val),
      .b     (rt_val),
      .shamt (shamt),
      .funct (funct),
      .f     (exp_f),
      .of    (exp_of),
      .zf    (exp_zf),
      .legal (funct_ok)
   );

   assign legal = (op == 6'd0) && funct_ok;
   assign mism  = legal && ((exp_f != ALU_F) || (exp_of != OF) || (exp_zf != ZF));

   // Stage-2 instruction that completes the final required compare
   assign s1_last = s1.valid && s1.legal && (chk_cnt == LAST_CHK);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mon_valid) state_d = ST_RUN;
         ST_RUN: begin
            if (STOP_ON_ERR && s1.valid && s1.mism) state_d = ST_FAIL;
            else if (s1_last)                       state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_DONE;
         ST_FAIL: state_d = ST_FAIL;
         default: state_d = ST_IDLE;
      endcase
   end

   // An instruction arriving on the edge that ends the run is dropped
   assign accept = mon_valid &&
                   ((state_q == ST_IDLE) || ((state_q == ST_RUN) && (state_d == ST_RUN)));

   // ------------------------------------------------ shadow register file
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) shadow[i] <= 32'd0;
      end else begin
         if (pre_ok) shadow[pre_addr] <= pre_data;
         // later assignment wins when the instruction targets the preloaded reg
         if (accept && legal && (rd != 5'd0)) shadow[rd] <= exp_f;
      end
   end

   // ---------------------------------------------------------- stage 1
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
      end else begin
         s1.valid <= accept;
         s1.legal <= legal;
         s1.mism  <= mism;
         s1.inst  <= Inst_code;
         s1.exp_f <= exp_f;
         s1.got_f <= ALU_F;
      end
   end

   // ---------------------------------------------------------- stage 2
   always_ff @(posedge clk) begin
      if (reset) begin
         chk_cnt  <= 16'd0;
         err_cnt  <= 16'd0;
         ill_cnt  <= 16'd0;
         fail     <= 1'b0;
         err_inst <= 32'd0;
         err_exp  <= 32'd0;
         err_got  <= 32'd0;
      end else if (s1.valid) begin
         if (s1.legal) begin
            chk_cnt <= chk_cnt + 16'd1;
            if (s1.mism) begin
               if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
               if (!fail) begin
                  err_inst <= s1.inst;
                  err_exp  <= s1.exp_f;
                  err_got  <= s1.got_f;
               end
               fail <= 1'b1;
            end
         end else if (ill_cnt != 16'hFFFF) begin
            ill_cnt <= ill_cnt + 16'd1;
         end
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign pass = done && !fail;

endmodule
`default_nettype wire

// File: tb/tb_r_result_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_r_result_checker
//  Description : Self-checking bench for r_result_checker. Two instances
//                (stop-on-error and keep-counting) share one stimulus stream;
//                an instruction-level model predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_r_result_checker;

   localparam int NCHK = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mon_valid = 1'b0;
   logic [31:0] inst_code = 32'd0;
   logic [31:0] alu_f = 32'd0;
   logic        cpu_of = 1'b0;
   logic        cpu_zf = 1'b0;
   logic        pre_we = 1'b0;
   logic [4:0]  pre_addr = 5'd0;
   logic [31:0] pre_data = 32'd0;

   logic [1:0]  busy_o, done_o, fail_o, pass_o;
   logic [15:0] chk_o [2];
   logic [15:0] err_o [2];
   logic [15:0] ill_o [2];
   logic [31:0] einst_o [2];
   logic [31:0] eexp_o [2];
   logic [31:0] egot_o [2];

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   r_result_checker #(.N_CHECK(NCHK), .STOP_ON_ERR(1'b1)) u_dut_stop (
      .clk(clk), .reset(reset), .mon_valid(mon_valid), .Inst_code(inst_code),
      .ALU_F(alu_f), .OF(cpu_of), .ZF(cpu_zf), .pre_we(pre_we),
      .pre_addr(pre_addr), .pre_data(pre_data),
      .busy(busy_o[0]), .done(done_o[0]), .fail(fail_o[0]), .pass(pass_o[0]),
      .chk_cnt(chk_o[0]), .err_cnt(err_o[0]), .ill_cnt(ill_o[0]),
      .err_inst(einst_o[0]), .err_exp(eexp_o[0]), .err_got(egot_o[0])
   );

   r_result_checker #(.N_CHECK(NCHK), .STOP_ON_ERR(1'b0)) u_dut_cont (
      .clk(clk), .reset(reset), .mon_valid(mon_valid), .Inst_code(inst_code),
      .ALU_F(alu_f), .OF(cpu_of), .ZF(cpu_zf), .pre_we(pre_we),
      .pre_addr(pre_addr), .pre_data(pre_data),
      .busy(busy_o[1]), .done(done_o[1]), .fail(fail_o[1]), .pass(pass_o[1]),
      .chk_cnt(chk_o[1]), .err_cnt(err_o[1]), .ill_cnt(ill_o[1]),
      .err_inst(einst_o[1]), .err_exp(eexp_o[1]), .err_got(egot_o[1])
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   // Golden result from plain integer arithmetic
   function automatic void golden(input logic [31:0] w, input logic [31:0] a,
                                  input logic [31:0] b, output logic lg,
                                  output logic [31:0] f, output logic of);
      longint sa, sb, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lg = 1'b1; f = 32'd0; of = 1'b0; r = 0;
      if (w[31:26] != 6'd0) lg = 1'b0;
      else begin
         case (w[5:0])
            6'h20: begin r = sa + sb; f = r[31:0];
                         of = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            6'h22: begin r = sa - sb; f = r[31:0];
                         of = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            6'h24: f = a & b;
            6'h25: f = a | b;
            6'h26: f = a ^ b;
            6'h27: f = ~(a | b);
            6'h2A: f = (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: f = (a < b) ? 32'd1 : 32'd0;
            6'h00: f = b << w[10:6];
            6'h02: f = b >> w[10:6];
            default: lg = 1'b0;
         endcase
      end
   endfunction

   // ------------------------------------------------------------- model
   typedef enum int {M_IDLE, M_RUN, M_DONE, M_FAIL} mstate_t;
   mstate_t     m_st [2];
   int          m_chk [2], m_err [2], m_ill [2];
   bit          m_fail [2];
   logic [31:0] m_einst [2], m_eexp [2], m_egot [2];
   logic [31:0] m_reg [2][32];
   bit          p_v [2], p_legal [2], p_mm [2];
   logic [31:0] p_inst [2], p_exp [2], p_got [2];
   bit          m_init = 1'b0;
   logic        m_lg, m_of;
   logic [31:0] m_f;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_st[k] = M_IDLE; m_chk[k] = 0; m_err[k] = 0; m_ill[k] = 0;
            m_fail[k] = 1'b0; m_einst[k] = 0; m_eexp[k] = 0; m_egot[k] = 0;
            p_v[k] = 1'b0;
            for (int r = 0; r < 32; r++) m_reg[k][r] = 32'd0;
         end else begin
            // results of the instruction taken one edge ago become visible
            if (p_v[k]) begin
               if (p_legal[k]) begin
                  m_chk[k]++;
                  if (p_mm[k]) begin
                     if (m_err[k] < 65535) m_err[k]++;
                     if (!m_fail[k]) begin
                        m_einst[k] = p_inst[k]; m_eexp[k] = p_exp[k]; m_egot[k] = p_got[k];
                     end
                     m_fail[k] = 1'b1;
                  end
                  if (p_mm[k] && k == 0)   m_st[k] = M_FAIL;
                  else if (m_chk[k] == NCHK) m_st[k] = M_DONE;
               end else if (m_ill[k] < 65535) m_ill[k]++;
            end
            p_v[k] = 1'b0;
            if (m_st[k] == M_IDLE && pre_we && pre_addr != 5'd0) m_reg[k][pre_addr] = pre_data;
            if (mon_valid && (m_st[k] == M_IDLE || m_st[k] == M_RUN)) begin
               m_st[k] = M_RUN;
               golden(inst_code, m_reg[k][inst_code[25:21]], m_reg[k][inst_code[20:16]],
                      m_lg, m_f, m_of);
               p_v[k]     = 1'b1;
               p_legal[k] = m_lg;
               p_mm[k]    = m_lg && ((m_f !== alu_f) || (m_of !== cpu_of) ||
                                     ((m_f == 32'd0) !== cpu_zf));
               p_inst[k]  = inst_code; p_exp[k] = m_f; p_got[k] = alu_f;
               if (m_lg && inst_code[15:11] != 5'd0) m_reg[k][inst_code[15:11]] = m_f;
            end
         end
      end
      if (reset) m_init = 1'b1;
   end

   // ----------------------------------------------------------- compare
   always @(negedge clk) begin
      if (m_init) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(m_st[k] == M_RUN));
            check($sformatf("done[%0d]", k), 32'(done_o[k]), 32'(m_st[k] == M_DONE));
            check($sformatf("fail[%0d]", k), 32'(fail_o[k]), 32'(m_fail[k]));
            check($sformatf("pass[%0d]", k), 32'(pass_o[k]),
                  32'(m_st[k] == M_DONE && !m_fail[k]));
            check($sformatf("chk_cnt[%0d]", k), 32'(chk_o[k]), 32'(m_chk[k]));
            check($sformatf("err_cnt[%0d]", k), 32'(err_o[k]), 32'(m_err[k]));
            check($sformatf("ill_cnt[%0d]", k), 32'(ill_o[k]), 32'(m_ill[k]));
            check($sformatf("err_inst[%0d]", k), einst_o[k], m_einst[k]);
            check($sformatf("err_exp[%0d]", k), eexp_o[k], m_eexp[k]);
            check($sformatf("err_got[%0d]", k), egot_o[k], m_egot[k]);
         end
      end
   end

   // ---------------------------------------------------------- stimulus
   logic [5:0] ftab [10];

   task automatic cyc(input bit v, input logic [31:0] w, input logic [31:0] f,
                      input bit of, input bit zf);
      mon_valid = v; inst_code = w; alu_f = f; cpu_of = of; cpu_zf = zf;
      @(negedge clk);
      mon_valid = 1'b0; pre_we = 1'b0;
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // mode 0 correct, 1 corrupt F, 2 corrupt OF, 3 corrupt ZF
   task automatic rand_instr(input int mode, output logic [31:0] w, output logic [31:0] fexp);
      logic [4:0] rs, rt, rd, sh;
      logic [5:0] fn;
      logic lg, of;
      logic [31:0] f;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(1, 7));
      sh = 5'($urandom_range(0, 31));
      fn = ftab[$urandom_range(0, 9)];
      w  = rtype(rs, rt, rd, sh, fn);
      golden(w, m_reg[1][rs], m_reg[1][rt], lg, f, of);
      fexp = f;
      cyc(1'b1, w, (mode == 1) ? (f ^ 32'd1) : f, (mode == 2) ? ~of : of,
          (mode == 3) ? (f != 32'd0) : (f == 32'd0));
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check({tag, "_busy"}, 32'(busy_o[k]), 32'd0);
         check({tag, "_done"}, 32'(done_o[k]), 32'd0);
         check({tag, "_fail"}, 32'(fail_o[k]), 32'd0);
         check({tag, "_pass"}, 32'(pass_o[k]), 32'd0);
         check({tag, "_chk"},  32'(chk_o[k]),  32'd0);
         check({tag, "_err"},  32'(err_o[k]),  32'd0);
         check({tag, "_ill"},  32'(ill_o[k]),  32'd0);
         check({tag, "_einst"}, einst_o[k], 32'd0);
         check({tag, "_eexp"},  eexp_o[k],  32'd0);
         check({tag, "_egot"},  egot_o[k],  32'd0);
      end
   endtask

   initial begin
      logic [31:0] w, fe, first_w, first_e, sub_w;
      first_w = 0; first_e = 0;
      ftab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02};

      // reset state
      reset = 1'b1;
      @(negedge clk); @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      // overflowing add that the CPU reports correctly
      preload(5'd1, 32'h7FFF_FFFF);
      preload(5'd2, 32'h0000_0001);
      cyc(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'h8000_0000, 1'b1, 1'b0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      check("add_chk_cnt", 32'(chk_o[0]), 32'd1);
      check("add_fail", 32'(fail_o[0]), 32'd0);

      // sub r4,r2,r2 reported with wrong ZF
      sub_w = rtype(5'd2, 5'd2, 5'd4, 5'd0, 6'h22);
      cyc(1'b1, sub_w, 32'd0, 1'b0, 1'b0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      check("sub_fail", 32'(fail_o[0]), 32'd1);
      check("sub_err_inst", einst_o[0], 32'h0042_2022);
      check("sub_err_exp", eexp_o[0], 32'd0);
      check("sub_err_got", egot_o[0], 32'd0);
      check("sub_state_fail", {30'd0, busy_o[0], done_o[0]}, 32'd0);
      check("sub_cont_busy", 32'(busy_o[1]), 32'd1);
      check("sub_cont_err", 32'(err_o[1]), 32'd1);

      // dependent chain with same-cycle preload bypass, then illegal words
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      pre_we = 1'b1; pre_addr = 5'd1; pre_data = 32'h7FFF_FFFF;
      cyc(1'b1, rtype(5'd1, 5'd0, 5'd5, 5'd0, 6'h25), 32'h7FFF_FFFF, 1'b0, 1'b0);
      cyc(1'b1, rtype(5'd0, 5'd5, 5'd6, 5'd4, 6'h00), 32'hFFFF_FFF0, 1'b0, 1'b0);
      cyc(1'b1, 32'h8C00_0000, 32'd0, 1'b0, 1'b0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      check("lw_ill_cnt", 32'(ill_o[0]), 32'd1);
      check("lw_chk_cnt", 32'(chk_o[0]), 32'd2);
      check("chain_fail", 32'(fail_o[1]), 32'd0);
      preload(5'd6, 32'd0);                       // ignored outside IDLE
      cyc(1'b1, 32'h8C00_3000, 32'd0, 1'b0, 1'b0); // op!=0 with rd=6 bits
      cyc(1'b1, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h08), 32'd0, 1'b0, 1'b0);
      cyc(1'b1, rtype(5'd6, 5'd0, 5'd7, 5'd0, 6'h25), 32'hFFFF_FFF0, 1'b0, 1'b0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      check("ill_cnt3", 32'(ill_o[1]), 32'd3);
      check("r6_kept_chk", 32'(chk_o[1]), 32'd3);
      check("r6_kept_fail", 32'(fail_o[1]), 32'd0);

      // long run with three injected mismatches, stream runs past N_CHECK
      for (int i = 0; i < 66; i++) begin
         rand_instr((i == 10) ? 1 : (i == 30) ? 2 : (i == 50) ? 3 : 0, w, fe);
         if (i == 10) begin first_w = w; first_e = fe; end
      end
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      check("run_done", 32'(done_o[1]), 32'd1);
      check("run_chk", 32'(chk_o[1]), 32'd64);
      check("run_err", 32'(err_o[1]), 32'd3);
      check("run_pass", 32'(pass_o[1]), 32'd0);
      check("run_einst", einst_o[1], first_w);
      check("run_eexp", eexp_o[1], first_e);
      check("run_egot", egot_o[1], first_e ^ 32'd1);
      check("stop_err", 32'(err_o[0]), 32'd1);

      // reset in the middle of a run
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      preload(5'd1, 32'h1234_5678);
      for (int i = 0; i < 10; i++) rand_instr(0, w, fe);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      check("mid_chk10", 32'(chk_o[0]), 32'd10);
      check("mid_busy", 32'(busy_o[1]), 32'd1);
      reset = 1'b1;
      cyc(1'b1, rtype(5'd1, 5'd1, 5'd2, 5'd0, 6'h20), 32'd0, 1'b0, 1'b1);
      reset = 1'b0;
      check_zero("midrst");
      cyc(1'b1, rtype(5'd1, 5'd0, 5'd7, 5'd0, 6'h25), 32'd0, 1'b0, 1'b1);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      check("r1_cleared_fail", 32'(fail_o[1]), 32'd0);
      check("r1_cleared_chk", 32'(chk_o[1]), 32'd1);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/r_result_checker.md
# r_result_checker

Synthesizable checker at the receiving end of the R-type CPU's observation interface (`Inst_code`, `ALU_F`, `OF`, `ZF`). It consumes one retired instruction per valid cycle and keeps a shadow 32×32 register file. It computes the golden ALU result and flags, compares them against the CPU outputs, and reports pass/fail with the first-mismatch details. It sits beside `R_CPU` in simulation and on FPGA self-test builds.

## Interface
- `N_CHECK`, default 64: number of checked instructions after which the checker reaches DONE.
- `STOP_ON_ERR`, default 1: 1 = freeze in FAIL on first mismatch; 0 = keep counting.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mon_valid` in 1: `Inst_code`/`ALU_F`/`OF`/`ZF` hold one retired instruction this cycle.
- `Inst_code` in 32: instruction word from the CPU.
- `ALU_F` in 32: CPU result.
- `OF` in 1: CPU overflow flag.
- `ZF` in 1: CPU zero flag.
- `pre_we` in 1: shadow-register preload strobe; honoured only in IDLE.
- `pre_addr` in 5: preload register index.
- `pre_data` in 32: preload value.
- `busy` out 1: state is RUN.
- `done` out 1: state is DONE.
- `fail` out 1: at least one mismatch recorded.
- `pass` out 1: `done & ~fail`.
- `chk_cnt` out 16: number of compared instructions.
- `err_cnt` out 16: number of mismatches, saturating at 0xFFFF.
- `ill_cnt` out 16: non-R-type or unsupported-funct words, saturating.
- `err_inst` out 32: `Inst_code` of the first mismatch.
- `err_exp` out 32: expected F of the first mismatch.
- `err_got` out 32: `ALU_F` of the first mismatch.

## Operation
- Reset sets all outputs and counters to 0 and all `err_*` fields to 0, clears the shadow regfile to 0, and puts the FSM in IDLE.
- Decode fields:
  - op = [31:26]; an instruction is R-type only when op = 0.
  - rs = [25:21], rt = [20:16], rd = [15:11], shamt = [10:6], funct = [5:0].
- Supported functs and their results:
  - 0x20 add: F = rs + rt; OF = signed overflow.
  - 0x22 sub: F = rs − rt; OF = signed overflow.
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor: bitwise result.
  - 0x2A slt: signed compare, result 0/1.
  - 0x2B sltu: unsigned compare, result 0/1.
  - 0x00 sll: F = rt << shamt.
  - 0x02 srl: F = rt >> shamt, logical.
- For all functs other than add/sub, expected OF = 0. Expected ZF = (F == 0).
- Arithmetic is 32-bit with wrap-around. Overflow for add: operands have the same sign and the result sign differs. Overflow for sub: operands have different signs and the result sign differs from rs.
- Shadow write: rd ← expected F, including when OF = 1. A write to rd = 0 is discarded, so r0 always reads 0.
- Illegal word (op ≠ 0 or unsupported funct): `ill_cnt`+1, no compare, no shadow write, `chk_cnt` unchanged.
- Mismatch: any of F, OF, ZF differs from the expected value.
- FSM transitions:
  - IDLE → RUN on the first `mon_valid`; that instruction is processed.
  - RUN → DONE when `chk_cnt` reaches `N_CHECK`.
  - RUN → FAIL on a mismatch, only when `STOP_ON_ERR` = 1.
  - DONE and FAIL are sticky until `reset`; `mon_valid` is ignored in both.
- Preload in IDLE writes shadow[`pre_addr`] ← `pre_data`, except `pre_addr` = 0. `pre_we` in any other state is ignored.
- `pre_we` and `mon_valid` in the same IDLE cycle: the preload is applied first. The instruction then reads the preloaded value through a bypass.

## Timing
- Stage 1, at sample edge E:
  - Expected result computed combinationally from the inputs and the shadow regfile.
  - Shadow write, registered mismatch flag, registered expected/got values.
- Back-to-back dependent instructions at E and E+1 read the value written at E. No stall, no bypass needed.
- Stage 2, at edge E+1: `chk_cnt`/`err_cnt`/`ill_cnt`, `fail`, `err_*` capture and state update become visible.
  - Latency from sample to counters is exactly 1 cycle after E.
- `err_*` capture only the first mismatch; later mismatches only increment `err_cnt`.
- DONE is entered on the edge where `chk_cnt` becomes `N_CHECK`. A valid arriving in that same stage-1 cycle is dropped.
- `reset` asserted mid-RUN flushes the stage-1 register and returns to IDLE at that edge.

## Structure
- Package `r_chk_pkg`:
  - funct localparams (`F_ADD` … `F_SRL`).
  - state enum IDLE/RUN/DONE/FAIL.
  - field-slice constants.
- Sub-module `r_alu_model`: combinational golden ALU with inputs a, b, shamt, funct and outputs f, of, zf, legal.
- Top level holds the shadow regfile, the two pipeline stages, the counters and the FSM.

## Test plan
- Preload r1 = 0x7FFFFFFF, r2 = 1; add r3,r1,r2 with `ALU_F` = 0x80000000, OF = 1, ZF = 0 -> no error; `chk_cnt` = 1 at E+1.
- sub r4,r2,r2 with `ALU_F` = 0, ZF = 0 (wrong flag) -> `fail` = 1 at E+1; `err_inst` = that word; `err_exp` = 0; `err_got` = 0; state FAIL.
- Dependent chain on consecutive cycles: or r5,r1,r0 then sll r6,r5,shamt = 4 -> expected 0xFFFFFFF0; matching DUT values give no error.
- Word 0x8C000000 (lw) -> `ill_cnt` = 1, `chk_cnt` unchanged, shadow untouched.
- `STOP_ON_ERR` = 0, 64 valid instructions with 3 injected mismatches -> `done` = 1, `err_cnt` = 3, `pass` = 0, `err_*` hold the first mismatch.
- Reset asserted while RUN with `chk_cnt` = 10 -> all outputs 0 and state IDLE on the next edge; shadow r1 reads 0.
